sram_read_arbiter: RTL and testbench
====================================

Name: sram_read_arbiter

Overview:
- Round-robin arbiter that shares the single read port of one SRAM macro (input, weights or scratchpad) among up to NUM_REQ requesters inside MyDesign, e.g. weight loader, input fetcher and a second conv lane.
- Accepts one read per cycle and drives the SRAM read address from a register.
- Returns the read data and a one-hot valid, tagged to the requester that issued the read, with fixed 2-cycle latency.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 12, SRAM address width
DATA_W, 16, SRAM data width
MAX_LOCK, 8, maximum consecutive locked grants (used only with SRAM_ARB_LOCK_EN)

Ports:
clk  input  1  clock; all logic on posedge
reset  input  1  synchronous, active-high reset
arb_en  input  1  1 = grants allowed; 0 = gnt forced to 0
req  input  NUM_REQ  per-requester read request
req_addr  input  NUM_REQ*ADDR_W  flattened addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
req_lock  input  NUM_REQ  burst lock hint; ignored unless SRAM_ARB_LOCK_EN
gnt  output  NUM_REQ  combinational one-hot grant; handshake completes when req[i] & gnt[i] at posedge
sram_read_address  output  ADDR_W  registered address to the SRAM
sram_read_data  input  DATA_W  SRAM data, valid 1 cycle after the address is presented
rdata  output  DATA_W  read data returned to requesters
rvalid  output  NUM_REQ  one-hot: rdata belongs to requester i this cycle
busy  output  1  1 while any accepted read is still in flight

Behaviour:
- Reset (reset=1 at posedge):
  - rr_ptr=0, sram_read_address=0, valid pipeline cleared.
  - rvalid=0 and busy=0 from the next cycle.
  - gnt=0 whenever reset is high.
  - Reset mid-operation discards in-flight reads; no rvalid is produced for them.
- Grant (combinational):
  - gnt is 0 if arb_en=0 or req=0.
  - Otherwise gnt is one-hot for the first set req bit, searching from index rr_ptr upward with wrap modulo NUM_REQ.
  - gnt never depends on req_addr.
- Accept at posedge of cycle t (any gnt bit set):
  - sram_read_address <= req_addr[winner].
  - rr_ptr <= (winner+1) mod NUM_REQ.
  - tag1 <= one-hot winner.
- No accept: sram_read_address holds its value, tag1 <= 0, rr_ptr holds.
- Pipeline: tag2 <= tag1 every cycle. rvalid = tag2 and rdata = sram_read_data, combinational passthrough.
- Latency: accept in cycle t -> address presented in t+1 -> rvalid/rdata in t+2.
- Throughput: one accept per cycle; back-to-back accepts give back-to-back rvalid in order.
- busy = |tag1 | |tag2.
- Requester rule: hold req and req_addr stable until the cycle it sees gnt. Dropping req before gnt withdraws the request with no side effect.
- Simultaneous events:
  - A requester may re-request in the cycle after its accept; it then competes at lowest priority.
  - arb_en falling while reads are in flight does not cancel them.
- Width rules: winner index is $clog2(NUM_REQ) bits; pointer wrap from NUM_REQ-1 to 0 is explicit; no arithmetic on data.

Optional Feature:
- Macro: SRAM_ARB_LOCK_EN.
- Defined:
  - If the winner of cycle t had req_lock=1 and still has req=1 in cycle t+1, it wins again regardless of rr_ptr.
  - Lock counter counts consecutive locked grants. After MAX_LOCK of them the lock is ignored for one arbitration and normal round-robin resumes from winner+1.
  - Counter resets on reset, on req_lock=0, or on a grant to another requester.
- Not defined: req_lock is unused, no lock counter exists, arbitration is pure round-robin.

Test Plan:
- Reset: assert reset with req=4'b1111 -> gnt=0. After release, first grant gnt=4'b0001; rvalid=0 until 2 cycles after the first accept.
- Single requester 2, addr 12'h02A, SRAM model returns mem[42]=16'h7F01 -> gnt=4'b0100 same cycle; sram_read_address=12'h02A next cycle; rvalid=4'b0100 and rdata=16'h7F01 two cycles after accept.
- All four requesting continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3; 8 rvalid pulses in the same order with matching data; busy=1 throughout and for 2 cycles after.
- arb_en=0 for 3 cycles while req=4'b0011 -> gnt=0, no new address, busy falls after 2 cycles. On arb_en=1 the grant goes to the index at rr_ptr.
- Reset asserted one cycle after an accept of addr 12'h010 -> no rvalid appears for it; sram_read_address=0; rr_ptr=0.
- With SRAM_ARB_LOCK_EN, MAX_LOCK=8: requester 1 holds req and req_lock, requester 3 holds req -> requester 1 receives 8 consecutive grants, then requester 3 is granted once, then requester 1 again. Without the macro, grants alternate 1,3,1,3.

Source files
------------

// File: rtl/sram_read_arbiter.sv
// Round-robin arbiter sharing one SRAM read port; returns tagged data with 2-cycle latency.
// Optional burst lock enabled by defining SRAM_ARB_LOCK_EN.
module sram_read_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 16,
  parameter int MAX_LOCK = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      arb_en,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_lock,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         sram_read_address,
  input  logic [DATA_W-1:0]         sram_read_data,
  output logic [DATA_W-1:0]         rdata,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]   rr_ptr_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [NUM_REQ-1:0] tag1_reg;
  logic [NUM_REQ-1:0] tag2_reg;

  logic [IDX_W-1:0]   rr_winner;
  logic               rr_found;
  logic [IDX_W-1:0]   winner;
  logic               accept;
  logic [IDX_W-1:0]   rr_ptr_next;

  // Search upward from rr_ptr with explicit wrap; first requester found wins.
  always_comb begin
    int idx;
    rr_winner = '0;
    rr_found  = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!rr_found && req[idx]) begin
        rr_found  = 1'b1;
        rr_winner = IDX_W'(idx);
      end
    end
  end

`ifdef SRAM_ARB_LOCK_EN
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  logic [IDX_W-1:0] lock_owner_reg;
  logic             lock_valid_reg;
  logic [CNT_W-1:0] lock_cnt_reg;
  logic             lock_hold;

  // The previous locked winner keeps the port until its streak reaches MAX_LOCK.
  assign lock_hold = lock_valid_reg && req[lock_owner_reg] && (lock_cnt_reg < CNT_W'(MAX_LOCK));
  assign winner    = lock_hold ? lock_owner_reg : rr_winner;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_owner_reg <= '0;
      lock_valid_reg <= 1'b0;
      lock_cnt_reg   <= '0;
    end else if (accept) begin
      if (req_lock[winner]) begin
        lock_owner_reg <= winner;
        lock_valid_reg <= 1'b1;
        lock_cnt_reg   <= lock_hold ? lock_cnt_reg + 1'b1 : CNT_W'(1);
      end else begin
        lock_valid_reg <= 1'b0;
        lock_cnt_reg   <= '0;
      end
    end else if (lock_valid_reg && !req_lock[lock_owner_reg]) begin
      lock_valid_reg <= 1'b0;
      lock_cnt_reg   <= '0;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign winner      = rr_winner;
`endif

  assign accept = arb_en && !reset && rr_found;

  always_comb begin
    gnt = '0;
    if (accept) gnt[winner] = 1'b1;
  end

  assign rr_ptr_next = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg <= '0;
      addr_reg   <= '0;
      tag1_reg   <= '0;
      tag2_reg   <= '0;
    end else begin
      if (accept) begin
        addr_reg   <= req_addr[int'(winner)*ADDR_W +: ADDR_W];
        rr_ptr_reg <= rr_ptr_next;
      end
      tag1_reg <= gnt;
      tag2_reg <= tag1_reg;
    end
  end

  assign sram_read_address = addr_reg;
  assign rvalid            = tag2_reg;
  assign rdata             = sram_read_data;
  assign busy              = (|tag1_reg) | (|tag2_reg);

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Bench for sram_read_arbiter: queue-based reference model checked every cycle plus directed literal checks.
module tb_sram_read_arbiter;

  localparam int N        = 4;
  localparam int AW       = 12;
  localparam int DW       = 16;
  localparam int MAX_LOCK = 8;

  logic            clk;
  logic            reset;
  logic            arb_en;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_lock;
  logic [N-1:0]    gnt;
  logic [AW-1:0]   sram_read_address;
  logic [DW-1:0]   sram_read_data;
  logic [DW-1:0]   rdata;
  logic [N-1:0]    rvalid;
  logic            busy;

  int n_cmp;
  int n_fail;

  sram_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .reset(reset), .arb_en(arb_en), .req(req), .req_addr(req_addr),
    .req_lock(req_lock), .gnt(gnt), .sram_read_address(sram_read_address),
    .sram_read_data(sram_read_data), .rdata(rdata), .rvalid(rvalid), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return (a == 12'h02A) ? 16'h7F01 : {4'hA, a};
  endfunction

  // Registered-read SRAM: data for the presented address appears one cycle later.
  initial sram_read_data = '0;
  always @(posedge clk) sram_read_data <= mem_val(sram_read_address);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference model: pending reads with the cycle their data is due.
  typedef struct {
    int            due;
    int            idx;
    logic [AW-1:0] addr;
  } pend_t;

  pend_t         pend[$];
  int            cyc;
  int            m_rr;
  logic [AW-1:0] m_addr;
  int            m_owner;
  int            m_len;
  bit            m_live;

  function automatic logic [N-1:0] model_gnt(output int w);
    logic [N-1:0] g;
    g = '0;
    w = -1;
    if (reset || !arb_en || req == '0) return g;
`ifdef SRAM_ARB_LOCK_EN
    if (m_live && req[m_owner] && m_len < MAX_LOCK) w = m_owner;
`endif
    if (w < 0) begin
      for (int k = 0; k < N; k++)
        if (w < 0 && req[(m_rr + k) % N]) w = (m_rr + k) % N;
    end
    g[w] = 1'b1;
    return g;
  endfunction

  logic [N-1:0]  e_gnt;
  logic [N-1:0]  e_rvalid;
  logic [DW-1:0] e_rdata;
  logic          e_busy;
  int            e_w;

  always @(negedge clk) begin
    e_gnt    = model_gnt(e_w);
    e_rvalid = '0;
    e_rdata  = '0;
    e_busy   = 1'b0;
    foreach (pend[k]) begin
      if (pend[k].due == cyc) begin
        e_rvalid[pend[k].idx] = 1'b1;
        e_rdata = mem_val(pend[k].addr);
      end
      if (pend[k].due == cyc || pend[k].due == cyc + 1) e_busy = 1'b1;
    end
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("rvalid", 32'(rvalid), 32'(e_rvalid));
    check("busy", 32'(busy), 32'(e_busy));
    check("sram_read_address", 32'(sram_read_address), 32'(m_addr));
    if (e_rvalid != '0) check("rdata", 32'(rdata), 32'(e_rdata));

    if (reset) begin
      pend.delete();
      m_rr = 0; m_addr = '0; m_live = 0; m_len = 0; m_owner = 0;
    end else if (e_w >= 0) begin
      pend.push_back('{cyc + 2, e_w, req_addr[e_w*AW +: AW]});
      m_addr = req_addr[e_w*AW +: AW];
      if (req_lock[e_w]) begin
        m_len   = (m_live && m_owner == e_w && m_len < MAX_LOCK) ? m_len + 1 : 1;
        m_owner = e_w;
        m_live  = 1;
      end else begin
        m_live = 0; m_len = 0;
      end
      m_rr = (e_w + 1) % N;
    end else if (m_live && !req_lock[m_owner]) begin
      m_live = 0; m_len = 0;
    end
    while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] order [0:9];
  logic [N-1:0] lock_exp [0:9];

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0;
    m_rr = 0; m_addr = '0; m_owner = 0; m_len = 0; m_live = 0;
    reset = 1'b1; arb_en = 1'b1; req = 4'b1111; req_lock = '0;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(12'h100 + i);

    // Reset holds gnt low even with all requests pending.
    tick(); #1 check("reset_gnt", 32'(gnt), 32'h0);
    tick(); tick();
    reset = 1'b0;
    #1 check("first_gnt", 32'(gnt), 32'h1);
    tick(); req = '0;
    #1 check("rvalid_t1", 32'(rvalid), 32'h0);
    tick(); #1 check("rvalid_t2", 32'(rvalid), 32'h1);
    check("rdata_t2", 32'(rdata), 32'(16'hA100));

    // Single requester 2 reading address 0x02A.
    tick(); req_addr[2*AW +: AW] = 12'h02A; req = 4'b0100;
    #1 check("single_gnt", 32'(gnt), 32'h4);
    tick(); req = '0;
    #1 check("single_addr", 32'(sram_read_address), 32'h02A);
    tick(); #1 check("single_rvalid", 32'(rvalid), 32'h4);
    check("single_rdata", 32'(rdata), 32'h7F01);

    // Four continuous requesters after a fresh reset.
    tick(); reset = 1'b1;
    tick(); reset = 1'b0; req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1 order[i] = gnt;
      tick();
    end
    req = '0;
    for (int i = 0; i < 8; i++) check("rr_order", 32'(order[i]), 32'(1 << (i % 4)));
    #1 check("busy_tail1", 32'(busy), 32'h1);
    tick(); #1 check("busy_tail2", 32'(busy), 32'h1);
    tick(); #1 check("busy_tail3", 32'(busy), 32'h0);

    // arb_en low blocks grants; re-enable resumes at rr_ptr.
    arb_en = 1'b0; req = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      #1 check("arb_dis_gnt", 32'(gnt), 32'h0);
      tick();
    end
    arb_en = 1'b1;
    #1 check("arb_en_gnt", 32'(gnt), 32'h1);

    // Reset right after an accept discards the in-flight read.
    tick(); req = 4'b0001; req_addr[0 +: AW] = 12'h010;
    #1 check("pre_reset_gnt", 32'(gnt), 32'h1);
    tick(); req = '0; reset = 1'b1;
    tick(); reset = 1'b0;
    #1 check("post_reset_addr", 32'(sram_read_address), 32'h0);
    check("post_reset_rvalid", 32'(rvalid), 32'h0);
    check("post_reset_busy", 32'(busy), 32'h0);
    tick(); req = 4'b1111;
    #1 check("post_reset_gnt", 32'(gnt), 32'h1);

    // Requester 1 locks, requester 3 competes.
    tick(); req = '0;
    tick(); req = 4'b1010; req_lock = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      #1 order[i] = gnt;
      tick();
    end
    req = '0; req_lock = '0;
    for (int i = 0; i < 10; i++) begin
`ifdef SRAM_ARB_LOCK_EN
      lock_exp[i] = (i == 8) ? 4'b1000 : 4'b0010;
`else
      lock_exp[i] = (i % 2 == 0) ? 4'b0010 : 4'b1000;
`endif
      check("lock_order", 32'(order[i]), 32'(lock_exp[i]));
    end

    for (int i = 0; i < 4; i++) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
